// File: rtl/jpeg_dec_pkg.sv
// Shared constants for the JPEG decoder reorder stage: block geometry,
// FSM encodings and the zigzag-to-raster map.
package jpeg_dec_pkg;

    localparam int         BLK_SZ  = 64;
    localparam logic [3:0] ZRL_RUN = 4'd15;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_WAIT = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } rd_state_e;

    // Entry k holds the raster index of the k-th coefficient in zigzag order.
    localparam logic [5:0] ZZ2RAST [BLK_SZ] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] dezigzag(input logic [5:0] zz);
        return ZZ2RAST[zz];
    endfunction

endpackage

// File: rtl/jpeg_dec_reorder_if.sv
// Token input, coefficient output and status bundle of the reorder stage.
interface jpeg_dec_reorder_if #(parameter int DW = 12);
    logic          PI_EN;
    logic [DW-1:0] PI;
    logic          PI_DC;
    logic          PI_LST;
    logic [3:0]    PI_ZR;
    logic          REORD_AFULL;
    logic          IDCT_BUSY;
    logic          PO_EN;
    logic [DW-1:0] PO;
    logic          PO_SOB;
    logic          PO_EOB;
    logic          ERR_OVR;
    logic          ERR_DROP;

    modport master (
        output PI_EN, PI, PI_DC, PI_LST, PI_ZR, IDCT_BUSY,
        input  REORD_AFULL, PO_EN, PO, PO_SOB, PO_EOB, ERR_OVR, ERR_DROP
    );

    modport slave (
        input  PI_EN, PI, PI_DC, PI_LST, PI_ZR, IDCT_BUSY,
        output REORD_AFULL, PO_EN, PO, PO_SOB, PO_EOB, ERR_OVR, ERR_DROP
    );
endinterface

// File: rtl/jpeg_dec_reord_skid.sv
// Small synchronous FIFO absorbing tokens in flight while backpressure propagates.
module jpeg_dec_reord_skid #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge HCLK) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/jpeg_dec_reorder.sv
// Rebuilds 8x8 blocks from run-length tokens into ping-pong banks and streams
// each finished block out in raster order.
module jpeg_dec_reorder
    import jpeg_dec_pkg::*;
#(
    parameter int DW           = 12,
    parameter int SKID_DEPTH   = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              INIT,
    jpeg_dec_reorder_if.slave bus
);
    localparam int TW = DW + 6;
    localparam int CW = $clog2(SKID_DEPTH) + 1;

    logic [TW-1:0] skid_rdata;
    logic          skid_full, skid_empty, skid_pop;
    logic [CW-1:0] skid_cnt;

    jpeg_dec_reord_skid #(.WIDTH(TW), .DEPTH(SKID_DEPTH)) u_skid (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clr_i   (INIT),
        .push_i  (bus.PI_EN),
        .pop_i   (skid_pop),
        .wdata_i ({bus.PI, bus.PI_DC, bus.PI_LST, bus.PI_ZR}),
        .rdata_o (skid_rdata),
        .full_o  (skid_full),
        .empty_o (skid_empty),
        .count_o (skid_cnt)
    );

    logic [DW-1:0] tok_val;
    logic          tok_dc, tok_lst;
    logic [3:0]    tok_zr;
    assign {tok_val, tok_dc, tok_lst, tok_zr} = skid_rdata;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [6:0]        zzp_q, zzp_d, pos;
    logic [5:0]        r_q, r_d, wr_addr;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [BLK_SZ-1:0] bitmap_q [2];
    logic [DW-1:0]     mem_q [2*BLK_SZ];
    logic              wr_en, ovr_set, blk_done, issue, rel_bank;
    logic              afull_q, afull_d, err_ovr_q, err_drop_q;
    logic              po_en_q, po_sob_q, po_eob_q;
    logic [DW-1:0]     po_q;

    // Seven bits so a run past the end of the block shows up as pos > 63.
    assign pos     = (tok_dc ? 7'd0 : zzp_q) + {3'd0, tok_zr};
    assign wr_addr = dezigzag(pos[5:0]);
    assign afull_d = (CW'(SKID_DEPTH) - skid_cnt) <= CW'(AFULL_MARGIN);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        zzp_d      = zzp_q;
        skid_pop   = 1'b0;
        wr_en      = 1'b0;
        ovr_set    = 1'b0;
        blk_done   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (!bank_full_q[wr_bank_q] && !skid_empty) begin
                    wr_state_d = W_FILL;
                    zzp_d      = 7'd0;
                end
            end
            W_FILL: begin
                if (!skid_empty) begin
                    skid_pop = 1'b1;
                    if (pos <= 7'd63) begin
                        wr_en = 1'b1;
                        zzp_d = pos + 7'd1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                    if (tok_lst) begin
                        blk_done   = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        wr_state_d = bank_full_q[~wr_bank_q] ? W_WAIT : W_IDLE;
                    end
                end
            end
            W_WAIT: begin
                if (!bank_full_q[wr_bank_q]) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Idle issues index 0 directly so a freshly filled bank starts the cycle after.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        r_d        = r_q;
        issue      = 1'b0;
        rel_bank   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (bank_full_q[rd_bank_q] && !bus.IDCT_BUSY) begin
                    issue      = 1'b1;
                    r_d        = r_q + 6'd1;
                    rd_state_d = R_RUN;
                end
            end
            R_RUN: begin
                if (!bus.IDCT_BUSY) begin
                    issue = 1'b1;
                    r_d   = r_q + 6'd1;
                    if (r_q == 6'd63) begin
                        rel_bank   = 1'b1;
                        rd_bank_d  = ~rd_bank_q;
                        rd_state_d = bank_full_q[~rd_bank_q] ? R_RUN : R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        bank_full_d = bank_full_q;
        if (rel_bank) bank_full_d[rd_bank_q] = 1'b0;
        if (blk_done) bank_full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) mem_q[{wr_bank_q, wr_addr}] <= tok_val;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_state_q  <= W_IDLE;
            rd_state_q  <= R_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            zzp_q       <= '0;
            r_q         <= '0;
            bank_full_q <= '0;
            bitmap_q[0] <= '0;
            bitmap_q[1] <= '0;
            afull_q     <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_drop_q  <= 1'b0;
            po_en_q     <= 1'b0;
            po_sob_q    <= 1'b0;
            po_eob_q    <= 1'b0;
            po_q        <= '0;
        end else if (INIT) begin
            wr_state_q  <= W_IDLE;
            rd_state_q  <= R_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            zzp_q       <= '0;
            r_q         <= '0;
            bank_full_q <= '0;
            bitmap_q[0] <= '0;
            bitmap_q[1] <= '0;
            afull_q     <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_drop_q  <= 1'b0;
            po_en_q     <= 1'b0;
            po_sob_q    <= 1'b0;
            po_eob_q    <= 1'b0;
            po_q        <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            zzp_q       <= zzp_d;
            r_q         <= r_d;
            bank_full_q <= bank_full_d;
            afull_q     <= afull_d;
            err_ovr_q   <= err_ovr_q | ovr_set;
            err_drop_q  <= err_drop_q | (bus.PI_EN & skid_full);
            po_en_q     <= issue;
            po_sob_q    <= issue && (r_q == 6'd0);
            po_eob_q    <= issue && (r_q == 6'd63);
            if (issue) po_q <= bitmap_q[rd_bank_q][r_q] ? mem_q[{rd_bank_q, r_q}] : '0;
            if (rel_bank) bitmap_q[rd_bank_q] <= '0;
            if (wr_en) bitmap_q[wr_bank_q][wr_addr] <= 1'b1;
        end
    end

    assign bus.REORD_AFULL = afull_q;
    assign bus.PO_EN       = po_en_q;
    assign bus.PO          = po_q;
    assign bus.PO_SOB      = po_sob_q;
    assign bus.PO_EOB      = po_eob_q;
    assign bus.ERR_OVR     = err_ovr_q;
    assign bus.ERR_DROP    = err_drop_q;
endmodule

// File: tb/tb_jpeg_dec_reorder.sv
// Bench for jpeg_dec_reorder: directed and random blocks checked against a
// token-level dezigzag / zero-fill model.
module tb_jpeg_dec_reorder;

    typedef struct {
        int val;
        bit dc;
        bit lst;
        int zr;
    } tok_t;

    typedef struct {
        int val;
        bit sob;
        bit eob;
    } exp_t;

    logic clk;
    logic rst_n;
    logic init;

    jpeg_dec_reorder_if #(.DW(12)) bus ();

    jpeg_dec_reorder #(.DW(12), .SKID_DEPTH(4), .AFULL_MARGIN(2)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .INIT    (init),
        .bus     (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   zz2r [64];
    tok_t tq [$];
    exp_t exp_q [$];
    bit   exp_ovr = 0;
    bit   chk_gap = 1;
    int   cyc = 0;
    int   sob_cyc = 0;
    int   last_eob_cyc = -10;
    int   b2b_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walk the anti-diagonals: odd diagonals run down-left, even ones up-right.
    function automatic void build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int row = lo; row <= hi; row++) begin
                    zz2r[k] = row * 8 + (s - row);
                    k++;
                end
            end else begin
                for (int row = hi; row >= lo; row--) begin
                    zz2r[k] = row * 8 + (s - row);
                    k++;
                end
            end
        end
    endfunction

    task automatic model_block();
        int   blk [64];
        int   zzp = 0;
        int   p;
        exp_t e;
        foreach (blk[i]) blk[i] = 0;
        foreach (tq[i]) begin
            p = (tq[i].dc ? 0 : zzp) + tq[i].zr;
            if (p < 64) begin
                blk[zz2r[p]] = tq[i].val;
                zzp = p + 1;
            end else begin
                exp_ovr = 1;
            end
        end
        for (int r = 0; r < 64; r++) begin
            e.val = blk[r];
            e.sob = (r == 0);
            e.eob = (r == 63);
            exp_q.push_back(e);
        end
    endtask

    task automatic add_tok(input int val, input bit dc, input bit lst, input int zr);
        tok_t t;
        t.val = val; t.dc = dc; t.lst = lst; t.zr = zr;
        tq.push_back(t);
    endtask

    task automatic gen_rand_block();
        int zzp = 1;
        int zr;
        int n;
        tq.delete();
        add_tok($urandom_range(0, 4095), 1'b1, 1'b0, 0);
        n = $urandom_range(0, 24);
        for (int i = 0; i < n; i++) begin
            zr = (i % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            if (zzp + zr > 63) break;
            add_tok($urandom_range(0, 4095), 1'b0, 1'b0, zr);
            zzp = zzp + zr + 1;
        end
        tq[tq.size()-1].lst = 1'b1;
    endtask

    task automatic send_tok(input tok_t t);
        int n = 0;
        while (bus.REORD_AFULL && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_val("afull_stuck", 1, 0);
        bus.PI_EN  = 1'b1;
        bus.PI     = 12'(t.val);
        bus.PI_DC  = t.dc;
        bus.PI_LST = t.lst;
        bus.PI_ZR  = 4'(t.zr);
        @(negedge clk);
        bus.PI_EN  = 1'b0;
    endtask

    task automatic send_block(input bit gaps);
        foreach (tq[i]) begin
            send_tok(tq[i]);
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_left", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        exp_ovr = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !init && bus.PO_EN) begin
            if (exp_q.size() == 0) begin
                check_val("po_spurious", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("po_val", int'(bus.PO), e.val);
                check_val("po_sob", int'(bus.PO_SOB), int'(e.sob));
                check_val("po_eob", int'(bus.PO_EOB), int'(e.eob));
            end
            if (bus.PO_SOB) begin
                if (cyc == last_eob_cyc + 1) b2b_cnt++;
                sob_cyc = cyc;
            end
            if (bus.PO_EOB) begin
                if (chk_gap) check_val("blk_span", cyc - sob_cyc, 63);
                last_eob_cyc = cyc;
            end
        end
    end

    initial begin
        int b2b_before;
        bit done;
        build_zz();
        rst_n = 1'b0;
        init = 1'b0;
        bus.PI_EN = 1'b0; bus.PI = '0; bus.PI_DC = 1'b0; bus.PI_LST = 1'b0;
        bus.PI_ZR = '0; bus.IDCT_BUSY = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_po_en", bus.PO_EN, 0);
        check_val("rst_po", int'(bus.PO), 0);
        check_val("rst_sob", bus.PO_SOB, 0);
        check_val("rst_eob", bus.PO_EOB, 0);
        check_val("rst_afull", bus.REORD_AFULL, 0);
        check_val("rst_ovr", bus.ERR_OVR, 0);
        check_val("rst_drop", bus.ERR_DROP, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // DC-only block
        tq.delete();
        add_tok(100, 1'b1, 1'b1, 0);
        model_block();
        send_block(1'b0);
        wait_drain();

        // zigzag placement
        tq.delete();
        add_tok(5, 1'b1, 1'b0, 0);
        add_tok(7, 1'b0, 1'b0, 0);
        add_tok(9, 1'b0, 1'b1, 1);
        model_block();
        send_block(1'b0);
        wait_drain();

        // ZRL runs then an overrunning token
        tq.delete();
        add_tok(33, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) add_tok(0, 1'b0, 1'b0, 15);
        add_tok(4, 1'b0, 1'b1, 15);
        model_block();
        send_block(1'b0);
        wait_drain();
        check_val("ovr_flag", bus.ERR_OVR, int'(exp_ovr));
        check_val("ovr_no_drop", bus.ERR_DROP, 0);
        pulse_init();
        check_val("init_clr_ovr", bus.ERR_OVR, 0);

        // three blocks under a stalled IDCT
        bus.IDCT_BUSY = 1'b1;
        b2b_before = b2b_cnt;
        fork
            begin
                tq.delete();
                add_tok(11, 1'b1, 1'b1, 0);
                model_block();
                send_block(1'b0);
                tq.delete();
                add_tok(22, 1'b1, 1'b0, 0);
                add_tok(3, 1'b0, 1'b1, 2);
                model_block();
                send_block(1'b0);
                tq.delete();
                add_tok(44, 1'b1, 1'b0, 0);
                for (int i = 0; i < 4; i++) add_tok(50 + i, 1'b0, 1'b0, i);
                add_tok(99, 1'b0, 1'b1, 1);
                model_block();
                send_block(1'b0);
            end
            begin
                int n = 0;
                while (!bus.REORD_AFULL && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                check_val("afull_assert", bus.REORD_AFULL, 1);
                check_val("afull_no_drop", bus.ERR_DROP, 0);
                repeat (20) @(negedge clk);
                bus.IDCT_BUSY = 1'b0;
            end
        join
        wait_drain();
        check_val("b2b_blocks", b2b_cnt - b2b_before, 2);
        check_val("bp_no_drop", bus.ERR_DROP, 0);

        // random blocks with random IDCT stalls
        chk_gap = 0;
        done = 0;
        fork
            begin
                for (int b = 0; b < 100; b++) begin
                    gen_rand_block();
                    model_block();
                    send_block(1'b1);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    bus.IDCT_BUSY = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.IDCT_BUSY = 1'b0;
            end
        join
        wait_drain();
        check_val("rand_ovr", bus.ERR_OVR, int'(exp_ovr));
        check_val("rand_drop", bus.ERR_DROP, 0);
        chk_gap = 1;

        // INIT in the middle of a block
        tq.delete();
        add_tok(321, 1'b1, 1'b0, 0);
        for (int i = 0; i < 9; i++) add_tok(10 + i, 1'b0, 1'b0, 1);
        send_block(1'b0);
        repeat (2) @(negedge clk);
        pulse_init();
        check_val("init_po_en", bus.PO_EN, 0);
        check_val("init_po", int'(bus.PO), 0);
        check_val("init_sob", bus.PO_SOB, 0);
        check_val("init_eob", bus.PO_EOB, 0);
        check_val("init_afull", bus.REORD_AFULL, 0);
        check_val("init_drop", bus.ERR_DROP, 0);
        gen_rand_block();
        model_block();
        send_block(1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
